// File: rtl/srf04_pkg.sv
// Shared SRF04 definitions: FSM state encoding and the sound-speed conversion constant.
package srf04_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Round-trip echo time per centimetre; the trigger generator derives its period from it too.
  localparam int unsigned SRF04_US_PER_CM = 58;
  localparam int unsigned SRF04_US_DIV    = 50;

endpackage

// File: rtl/srf04_sync_edge.sv
// 2-FF synchroniser for the async ECHO line plus registered rise/fall detection.
module srf04_sync_edge (
  input  logic clkin,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Both flags see the same 3-cycle latency, so the measured width is exact.
  always_ff @(posedge clkin) begin
    if (!rstn) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      rise <= s2 & ~s3;
      fall <= ~s2 & s3;
    end
  end

endmodule

// File: rtl/srf04_echo_timer.sv
// Times the SRF04 echo pulse in microseconds after a trigger and converts it to centimetres.
module srf04_echo_timer
  import srf04_pkg::*;
#(
  parameter int unsigned US_DIV    = SRF04_US_DIV,
  parameter int unsigned US_PER_CM = SRF04_US_PER_CM,
  parameter int unsigned WW        = 16,
  parameter int unsigned DW        = 10,
  parameter int unsigned MAX_US    = 30000,
  parameter int unsigned ARM_TO_US = 1000
) (
  input  logic          clkin,
  input  logic          rstn,
  input  logic          en,
  input  logic          trig,
  input  logic          echo,
  output logic [WW-1:0] width_us,
  output logic [DW-1:0] dist_cm,
  output logic          valid,
  output logic          timeout,
  output logic          busy
);

  localparam int unsigned PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned AW = $clog2(ARM_TO_US + 1);
  localparam int unsigned SW = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

  logic rise, fall;

  srf04_sync_edge u_sync (
    .clkin (clkin),
    .rstn  (rstn),
    .din   (echo),
    .rise  (rise),
    .fall  (fall)
  );

  state_t        state;
  logic [PW-1:0] pre;
  logic [AW-1:0] arm_cnt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [DW-1:0] cm_cnt, cm_nxt;
  logic [SW-1:0] sub_cnt, sub_nxt;
  logic          us_tick, arm_hit, max_hit;

  assign us_tick = (pre == PW'(US_DIV - 1));
  // Fires on the tick that brings the arm timer to ARM_TO_US.
  assign arm_hit = us_tick && (arm_cnt >= AW'(ARM_TO_US - 1));
  assign max_hit = (wcnt == WW'(MAX_US));
  assign busy    = (state != IDLE);

  // Next counter values are shared by MEASURE and the result latch, so the tick
  // landing on the fall cycle is still counted.
  always_comb begin
    wcnt_nxt = wcnt;
    cm_nxt   = cm_cnt;
    sub_nxt  = sub_cnt;
    if (us_tick) begin
      if (wcnt != WW'(MAX_US) && wcnt != '1) wcnt_nxt = wcnt + 1'b1;
      if (sub_cnt == SW'(US_PER_CM - 1)) begin
        sub_nxt = '0;
        if (cm_cnt != '1) cm_nxt = cm_cnt + 1'b1;
      end else begin
        sub_nxt = sub_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstn) begin
      state    <= IDLE;
      pre      <= '0;
      arm_cnt  <= '0;
      wcnt     <= '0;
      cm_cnt   <= '0;
      sub_cnt  <= '0;
      width_us <= '0;
      dist_cm  <= '0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      pre     <= us_tick ? '0 : pre + 1'b1;
      if (!en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              state   <= ARMED;
              arm_cnt <= '0;
              pre     <= '0;
            end
          end
          ARMED: begin
            if (us_tick && arm_cnt != '1) arm_cnt <= arm_cnt + 1'b1;
            if (rise) begin
              state   <= MEASURE;
              pre     <= '0;
              wcnt    <= '0;
              cm_cnt  <= '0;
              sub_cnt <= '0;
            end else if (arm_hit) begin
              state   <= IDLE;
              timeout <= 1'b1;
            end
          end
          MEASURE: begin
            wcnt    <= wcnt_nxt;
            cm_cnt  <= cm_nxt;
            sub_cnt <= sub_nxt;
            if (fall || max_hit) begin
              state    <= DONE;
              valid    <= 1'b1;
              timeout  <= ~fall;
              width_us <= wcnt_nxt;
              dist_cm  <= cm_nxt;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_srf04_echo_timer.sv
// Directed bench for srf04_echo_timer with small sim parameters (4 clk/us, 1000 us max).
module tb_srf04_echo_timer;

  localparam int WW = 16;
  localparam int DW = 10;

  logic          clkin = 1'b0;
  logic          rstn, en, trig, echo;
  logic [WW-1:0] width_us;
  logic [DW-1:0] dist_cm;
  logic          valid, timeout, busy;

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int nto    = 0;

  srf04_echo_timer #(
    .US_DIV(4), .US_PER_CM(58), .WW(WW), .DW(DW), .MAX_US(1000), .ARM_TO_US(100)
  ) dut (
    .clkin(clkin), .rstn(rstn), .en(en), .trig(trig), .echo(echo),
    .width_us(width_us), .dist_cm(dist_cm), .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clkin = ~clkin;

  always @(negedge clkin) begin
    if (valid)   nvalid++;
    if (timeout) nto++;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clkin);
    trig = 1'b0;
  endtask

  task automatic wait_strobe(input int maxc);
    for (int i = 0; i < maxc && !(valid || timeout); i++) @(negedge clkin);
  endtask

  // Full 2320-cycle echo (580 us -> 10 cm), optional trig pulses while measuring.
  task automatic run_meas(input string tag, input int trig_every);
    int v0, t0;
    v0 = nvalid;
    t0 = nto;
    pulse_trig();
    step(20);
    echo = 1'b1;
    for (int i = 0; i < 2320; i++) begin
      trig = (trig_every > 0) && (i % trig_every == trig_every / 2);
      @(negedge clkin);
    end
    trig = 1'b0;
    echo = 1'b0;
    wait_strobe(40);
    chk({tag, "_valid"}, valid, 1);
    chk({tag, "_width"}, width_us, 580);
    chk({tag, "_dist"}, dist_cm, 10);
    chk({tag, "_to"}, timeout, 0);
    @(negedge clkin);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_valid_1cyc"}, valid, 0);
    step(5);
    chk({tag, "_nvalid"}, nvalid - v0, 1);
    chk({tag, "_nto"}, nto - t0, 0);
  endtask

  initial begin
    int n, v0, t0;

    // 1: reset with echo and trig high
    rstn = 1'b0; en = 1'b0; trig = 1'b1; echo = 1'b1;
    step(3);
    chk("rst_width", width_us, 0);
    chk("rst_dist", dist_cm, 0);
    chk("rst_valid", valid, 0);
    chk("rst_to", timeout, 0);
    chk("rst_busy", busy, 0);
    trig = 1'b0; echo = 1'b0;
    rstn = 1'b1;
    step(5);
    en = 1'b1;
    step(2);

    // 2: nominal 580 us echo
    run_meas("t2", 0);

    // 3: missing echo -> arm timeout 400 cycles after arming
    v0 = nvalid;
    pulse_trig();
    n = 0;
    while (!timeout && n < 600) begin
      @(negedge clkin);
      n++;
    end
    chk("t3_to", timeout, 1);
    chk("t3_lat", (n >= 399 && n <= 401) ? 400 : n, 400);
    chk("t3_valid", valid, 0);
    chk("t3_width", width_us, 580);
    chk("t3_dist", dist_cm, 10);
    chk("t3_busy", busy, 0);
    step(3);
    chk("t3_nvalid", nvalid - v0, 0);

    // 4: echo stuck high -> MAX_US result with timeout
    pulse_trig();
    step(20);
    echo = 1'b1;
    wait_strobe(4400);
    chk("t4_valid", valid, 1);
    chk("t4_to", timeout, 1);
    chk("t4_width", width_us, 1000);
    chk("t4_dist", dist_cm, 17);
    echo = 1'b0;
    step(10);
    chk("t4_busy", busy, 0);

    // 5: drop en mid-measure, then a clean run
    v0 = nvalid;
    t0 = nto;
    pulse_trig();
    step(20);
    echo = 1'b1;
    step(100);
    en = 1'b0;
    @(negedge clkin);
    chk("t5_busy", busy, 0);
    echo = 1'b0;
    step(50);
    chk("t5_nvalid", nvalid - v0, 0);
    chk("t5_nto", nto - t0, 0);
    chk("t5_width_hold", width_us, 1000);
    en = 1'b1;
    step(2);
    run_meas("t5", 0);

    // 6: trig pulses during measure are ignored; reset mid-measure clears results
    run_meas("t6", 200);
    v0 = nvalid;
    pulse_trig();
    step(20);
    echo = 1'b1;
    step(500);
    chk("t6_busy_pre", busy, 1);
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    chk("t6_rst_width", width_us, 0);
    chk("t6_rst_dist", dist_cm, 0);
    chk("t6_rst_busy", busy, 0);
    step(20);
    echo = 1'b0;
    step(50);
    chk("t6_rst_nvalid", nvalid - v0, 0);
    chk("t6_rst_busy2", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
